// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port RAM with hardware init sweep.
package ram_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ram_state_t;

  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

  // Byte-lane merge at the widest supported word; callers cast to their own width.
  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(MAX_BE_W); i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Init/run FSM and sweep counter; drives the sweep write port and busy.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_we
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  ram_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              busy_q, busy_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_INIT;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_q <= busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (cnt == LAST) state_nxt = ST_RUN;
      ST_RUN:  if (clr) state_nxt = ST_INIT;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Counter and busy for the following cycle; busy is registered to track state
  always_comb begin
    cnt_nxt  = cnt;
    busy_nxt = (state_nxt == ST_INIT);
    if (state == ST_INIT) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + ADDR_W'(1);
    end
  end

  assign busy      = busy_q;
  assign init_we   = busy_q;
  assign init_addr = cnt;

endmodule

// File: rtl/ram_dp_init.sv
// Simple dual-port RAM: registered reads, byte-enable writes, write-first bypass,
// and a hardware sweep that fills the array with INIT_VAL after reset or clr.
module ram_dp_init
  import ram_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                w_en,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_be,
  input  logic                r_en,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic [DATA_W-1:0]   r_data,
  output logic                r_valid,
  output logic                busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              user_we_c;
  logic              user_re_c;
  logic              bypass_c;
  logic [DATA_W-1:0] wr_merged_c;
  logic [DATA_W-1:0] rd_word_c;

  ram_init_seq #(
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .busy      (busy),
    .init_addr (init_addr),
    .init_we   (init_we)
  );

  assign user_we_c = w_en && !busy;
  assign user_re_c = r_en && !busy;
  assign bypass_c  = user_we_c && (w_addr == r_addr);

  assign wr_merged_c = DATA_W'(be_merge(MAX_DATA_W'(mem[w_addr]),
                                        MAX_DATA_W'(w_data),
                                        MAX_BE_W'(w_be)));
  // On a same-address collision the merged write word is exactly what the read must see
  assign rd_word_c = bypass_c ? wr_merged_c : mem[r_addr];

  // Array write port: the sweep owns it while busy
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= INIT_VAL;
    end else if (user_we_c) begin
      mem[w_addr] <= wr_merged_c;
    end
  end

  // Registered read port; r_data holds when no read is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= user_re_c;
      if (user_re_c) r_data <= rd_word_c;
    end
  end

endmodule

// File: doc/ram_dp_init.md
# ram_dp_init

Parametrised simple dual-port RAM, the successor to the 256×32 combinational data RAM used by the FSM datapath. It adds synchronous one-cycle reads with a valid flag, per-byte write enables and write-first read-during-write bypass. It also adds a hardware initialisation sweep that fills every word with `INIT_VAL` after reset or on request, with `busy` asserted while the sweep runs. The block sits between the control FSM (reader) and the ALU result path (writer).

## Interface
- `DATA_W`, 32, word width in bits; must be a multiple of 8.
- `ADDR_W`, 8, address width; DEPTH = 2^ADDR_W words.
- `INIT_VAL`, 0, `DATA_W`-bit value written to every word by the sweep.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  request a re-initialisation sweep (1-cycle pulse).
- `w_en`  in  1  write request.
- `w_addr`  in  ADDR_W  write address.
- `w_data`  in  DATA_W  write data.
- `w_be`  in  DATA_W/8  byte enables; bit i covers `w_data[8i+7:8i]`.
- `r_en`  in  1  read request.
- `r_addr`  in  ADDR_W  read address.
- `r_data`  out  DATA_W  registered read data.
- `r_valid`  out  1  `r_data` updated by a read accepted on the previous edge.
- `busy`  out  1  initialisation sweep in progress; requests are ignored.

## Operation
- FSM states: ST_INIT and ST_RUN. Reset forces ST_INIT with the sweep counter at 0.
- ST_INIT:
  - Each cycle writes `INIT_VAL` (all bytes) to address `cnt`, then `cnt` increments.
  - After the write to DEPTH-1, the FSM goes to ST_RUN and `cnt` returns to 0. No wrap past DEPTH-1 and no second pass.
  - `w_en`, `r_en` and `clr` are ignored, and `r_valid` stays 0.
- ST_RUN:
  - Write: `w_en`=1 updates each byte i of `mem[w_addr]` where `w_be[i]`=1; other bytes are unchanged. `w_be`=0 is a legal no-op.
  - Read: `r_en`=1 loads `r_data` ← `mem[r_addr]` and sets `r_valid`=1 for exactly one cycle. `r_en`=0 clears `r_valid`; `r_data` holds its last value.
  - Collision: `w_en` and `r_en` both 1 with `r_addr`==`w_addr` returns merged data (new bytes where `w_be`=1, old bytes elsewhere), i.e. write-first.
  - `clr`=1 enters ST_INIT on the next edge. Any write or read in that same cycle is still performed.
- Arithmetic:
  - Address compare is full `ADDR_W` width.
  - `cnt` is `ADDR_W` bits; terminal detect is `cnt`==DEPTH-1.
  - `INIT_VAL` is truncated or zero-extended to `DATA_W`.
- Reset mid-sweep restarts the sweep at address 0. Reset mid-run discards nothing already written but starts a full sweep.
- The memory array itself has no reset; its contents are defined only by the sweep.

## Timing
- Reset values: `r_data`=0, `r_valid`=0, `busy`=1, state=ST_INIT, `cnt`=0.
- After `rst` falls, `busy` stays 1 for exactly DEPTH rising edges (256 at default). It is 0 from the cycle after the write to DEPTH-1.
- `clr` sampled on edge k in ST_RUN: `busy`=1 from edge k+1 for DEPTH cycles.
- Read latency is 1: request sampled on edge k; `r_data`/`r_valid` valid after edge k, during cycle k+1.
- Write latency is 1: a read of the same address on edge k+1 returns the new data. Same-edge reads are covered by the bypass.
- Back-to-back reads: one per cycle, `r_valid` continuously 1.

## Structure
- Package `ram_pkg` holds:
  - the state enum `ram_state_t` (ST_INIT, ST_RUN);
  - the function `be_merge(old, new, be)` used by both the write path and the bypass path.
- Sub-module `ram_init_seq` contains the FSM and sweep counter. Its outputs are `busy`, the sweep address and the sweep write strobe.
- The top level holds the array, the write mux (sweep vs user) and the read/bypass register.

## Test plan
- Sweep after reset, `INIT_VAL`=32'hA5A5A5A5: `busy` high for exactly 256 cycles after `rst` falls; reads of addresses 0, 128 and 255 then return A5A5A5A5 with `r_valid` 1 cycle later.
- Byte-enable write: write 32'h11223344 to addr 7 with `w_be`=4'b0101 over INIT 0; reading addr 7 returns 32'h00220044.
- Collision: `mem[3]`=32'hFFFFFFFF; in one cycle write 32'h12345678 with `w_be`=4'b1100 and read addr 3; `r_data`=32'h1234FFFF.
- Read hold: read addr 5 (=32'h55), then `r_en`=0 for 3 cycles; `r_valid` drops to 0 and `r_data` stays 32'h55.
- `clr` pulse after writing 32'hDEAD to addr 9: `busy` high for 256 cycles, requests during the sweep are ignored (`r_valid`=0), and addr 9 then reads `INIT_VAL`.
- `rst` asserted at sweep address 100: outputs return to reset values; after release the sweep runs the full 256 cycles starting at 0.
